alu: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_shifter.sv | 63 ++++++
 rtl/alu.sv | 98 +++++++++
 tb/tb_alu.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding, shift direction
// constants and the shift-amount width helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SHIFT = 3'd5
  } op_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Number of low bits of operand B used as the shift amount.
  function automatic int unsigned shamt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical barrel shifter with zero fill; also reports the
// last bit shifted out (0 when the amount is zero).
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = shamt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [AW-1:0]    amt_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] shifted_o,
  output logic             shout_o
);

  function automatic logic [WIDTH:0] rev(input logic [WIDTH:0] v);
    logic [WIDTH:0] r;
    r = '0;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      r[i] = v[WIDTH-i];
    end
    return r;
  endfunction

  logic [WIDTH:0] stage;
  logic [WIDTH:0] outv;

  // One guard bit catches the shift-out. Right shifts reuse the left-shift
  // stages on the bit-reversed {a, guard} vector and reverse back afterwards.
  always_comb begin
    stage     = '0;
    outv      = '0;
    shifted_o = '0;
    shout_o   = 1'b0;
    unique case (dir_i)
      DIR_LEFT:  stage = {1'b0, a_i};
      DIR_RIGHT: stage = rev({a_i, 1'b0});
      default:   stage = '0;
    endcase
    for (int unsigned k = 0; k < AW; k++) begin
      if (amt_i[k]) begin
        stage = stage << (1 << k);
      end
    end
    unique case (dir_i)
      DIR_LEFT: begin
        outv      = stage;
        shifted_o = outv[WIDTH-1:0];
        shout_o   = outv[WIDTH];
      end
      DIR_RIGHT: begin
        outv      = rev(stage);
        shifted_o = outv[WIDTH:1];
        shout_o   = outv[0];
      end
      default: begin
        shifted_o = '0;
        shout_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: add/sub/logic/shift datapath with zero,
// carry and overflow flags, all registered with one-cycle latency.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             dir,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned AW = shamt_width(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sh_val;
  logic             sh_out;
  op_e              opc;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;

  alu_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .a_i      (a),
    .amt_i    (b[AW-1:0]),
    .dir_i    (dir),
    .shifted_o(sh_val),
    .shout_o  (sh_out)
  );

  assign opc  = op_e'(op);
  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the extended difference is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (opc)
      OP_ADD: begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
        ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = diff[WIDTH-1:0];
        carry_d  = diff[WIDTH];
        ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   result_d = a & b;
      OP_OR:    result_d = a | b;
      OP_XOR:   result_d = a ^ b;
      OP_SHIFT: begin
        result_d = sh_val;
        carry_d  = sh_out;
      end
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
      end
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized bench for the 8-bit ALU with immediate-assertion checks.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       dir;
  logic [7:0] result;
  logic       zero, carry, overflow;

  int tests  = 0;
  int failed = 0;

  alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .op      (op),
    .dir     (dir),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] er, input logic ez,
                           input logic ec, input logic eo);
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, {7'd0, zero}, {7'd0, ez});
    check({tag, ".carry"}, {7'd0, carry}, {7'd0, ec});
    check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, eo});
  endtask

  // Drive at the falling edge, sample 1ns after the capturing rising edge.
  task automatic step(input logic [7:0] va, input logic [7:0] vb,
                      input logic [2:0] vop, input logic vdir);
    @(negedge clk);
    a = va; b = vb; op = vop; dir = vdir;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop,
                       input logic mdir, output logic [7:0] r, output logic z,
                       output logic c, output logic o);
    int sa, sb, s, amt;
    sa = ma[7] ? int'(ma) - 256 : int'(ma);
    sb = mb[7] ? int'(mb) - 256 : int'(mb);
    r = 8'h00; c = 1'b0; o = 1'b0;
    case (mop)
      3'd0: begin
        s = int'(ma) + int'(mb);
        r = s[7:0]; c = (s > 255);
        o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd1: begin
        s = int'(ma) - int'(mb) + 256;
        r = s[7:0]; c = (ma < mb);
        o = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd2: r = ma & mb;
      3'd3: r = ma | mb;
      3'd4: r = ma ^ mb;
      3'd5: begin
        amt = int'(mb) % 8;
        if (!mdir) begin
          s = (int'(ma) << amt);
          r = s[7:0];
          c = (amt != 0) && s[8];
        end else begin
          s = int'(ma) >> amt;
          r = s[7:0];
          c = (amt != 0) && ((int'(ma) >> (amt - 1)) % 2 == 1);
        end
      end
      default: r = 8'h00;
    endcase
    z = (r == 8'h00);
  endtask

  initial begin
    logic [7:0] ra, rb, er;
    logic [2:0] rop;
    logic       rdir, ez, ec, eo;

    rst_n = 1'b1;
    a = 8'h10; b = 8'h01; op = 3'd0; dir = 1'b0;

    // Capture something non-zero, then assert reset mid-cycle.
    @(posedge clk); #1;
    check("pre_reset.result", result, 8'h11);
    #2;
    a = 8'hFF; b = 8'h01; op = 3'd0;
    rst_n = 1'b0;
    #1;
    check_all("reset_async", 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_hold", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("first_capture", 8'h00, 1'b1, 1'b1, 1'b0);

    step(8'd200, 8'd100, 3'd0, 1'b0); check_all("add_carry", 8'd44, 1'b0, 1'b1, 1'b0);
    step(8'd100, 8'd100, 3'd0, 1'b0); check_all("add_ovf", 8'd200, 1'b0, 1'b0, 1'b1);
    step(8'd100, 8'd100, 3'd0, 1'b1); check_all("add_dir1", 8'd200, 1'b0, 1'b0, 1'b1);
    step(8'd5, 8'd10, 3'd1, 1'b0);    check_all("sub_borrow", 8'd251, 1'b0, 1'b1, 1'b0);
    step(8'h80, 8'h01, 3'd1, 1'b0);   check_all("sub_ovf", 8'h7F, 1'b0, 1'b0, 1'b1);
    step(8'd37, 8'd37, 3'd1, 1'b0);   check_all("sub_zero", 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hF0, 8'h0F, 3'd2, 1'b0);   check_all("and", 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hF0, 8'h0F, 3'd3, 1'b0);   check_all("or", 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'hAA, 8'hFF, 3'd4, 1'b0);   check_all("xor", 8'h55, 1'b0, 1'b0, 1'b0);
    step(8'h81, 8'd1, 3'd5, 1'b0);    check_all("shl1", 8'h02, 1'b0, 1'b1, 1'b0);
    step(8'h81, 8'd3, 3'd5, 1'b1);    check_all("shr3_c0", 8'h10, 1'b0, 1'b0, 1'b0);
    step(8'h84, 8'd3, 3'd5, 1'b1);    check_all("shr3_c1", 8'h10, 1'b0, 1'b1, 1'b0);
    step(8'h81, 8'd8, 3'd5, 1'b0);    check_all("shl_amt0", 8'h81, 1'b0, 1'b0, 1'b0);
    step(8'h81, 8'd7, 3'd5, 1'b0);    check_all("shl7", 8'h80, 1'b0, 1'b0, 1'b0);
    step(8'h81, 8'd7, 3'd5, 1'b1);    check_all("shr7", 8'h01, 1'b0, 1'b0, 1'b0);
    step(8'hFF, 8'hFF, 3'd6, 1'b0);   check_all("rsv6", 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hFF, 8'h01, 3'd7, 1'b1);   check_all("rsv7", 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset during a cycle with pending inputs: that capture is discarded.
    @(negedge clk);
    a = 8'd1; b = 8'd1; op = 3'd0; dir = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check_all("reset_discard", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("after_discard", 8'd2, 1'b0, 1'b0, 1'b0);

    // Back-to-back random vectors, one per cycle.
    for (int i = 0; i < 200; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rop  = 3'($urandom_range(0, 7));
      rdir = 1'($urandom);
      model(ra, rb, rop, rdir, er, ez, ec, eo);
      step(ra, rb, rop, rdir);
      check_all("rand", er, ez, ec, eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
